// File: rtl/led_pattern_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | led_pattern_gen : prescaled LED pattern engine (count/chaser/blink/breathe)|
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module led_pattern_gen #(
  parameter int N_LEDS     = 3,
  parameter int PRESCALE_W = 23,
  parameter int PWM_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] leds,
  output logic              tick
);

  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [POS_W-1:0] C_POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [PWM_W-1:0] C_DUTY_MAX = '1;

  localparam logic [1:0] C_MODE_COUNT   = 2'd0;
  localparam logic [1:0] C_MODE_CHASER  = 2'd1;
  localparam logic [1:0] C_MODE_BLINK   = 2'd2;
  localparam logic [1:0] C_MODE_BREATHE = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [N_LEDS-1:0]     step_q, step_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  dir_q, dir_d;
  logic [PWM_W-1:0]      duty_q, duty_d;
  logic                  ddir_q, ddir_d;
  logic                  blink_q, blink_d;
  logic [PWM_W-1:0]      pwm_ctr_q, pwm_ctr_d;
  logic [1:0]            mode_q, mode_d;
  logic [N_LEDS-1:0]     leds_q, leds_d;
  logic                  tick_q, tick_d;

  logic                  step_en;
  logic                  mode_chg;
  logic [N_LEDS-1:0]     onehot;

  always_comb begin
    step_en   = (pre_q == '1);
    mode_chg  = (mode != mode_q);
    pre_d     = pre_q + PRESCALE_W'(1);
    pwm_ctr_d = pwm_ctr_q + PWM_W'(1);
    tick_d    = step_en;
    mode_d    = mode;

    step_d  = step_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    ddir_d  = ddir_q;
    blink_d = blink_q;

    // A mode change wins over a coincident step so the new mode starts clean.
    if (mode_chg) begin
      step_d  = '0;
      pos_d   = '0;
      dir_d   = DIR_UP;
      duty_d  = '0;
      ddir_d  = DIR_UP;
      blink_d = 1'b0;
    end else if (step_en) begin
      case (mode_q)
        C_MODE_COUNT: step_d = step_q + N_LEDS'(1);
        C_MODE_CHASER: begin
          if (N_LEDS > 1) begin
            if (dir_q == DIR_UP) begin
              pos_d = pos_q + POS_W'(1);
              if (pos_d == C_POS_LAST) dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q - POS_W'(1);
              if (pos_d == '0) dir_d = DIR_UP;
            end
          end
        end
        C_MODE_BLINK: blink_d = ~blink_q;
        C_MODE_BREATHE: begin
          if (ddir_q == DIR_UP) begin
            duty_d = duty_q + PWM_W'(1);
            if (duty_d == C_DUTY_MAX) ddir_d = DIR_DOWN;
          end else begin
            duty_d = duty_q - PWM_W'(1);
            if (duty_d == '0) ddir_d = DIR_UP;
          end
        end
      endcase
    end

    onehot = N_LEDS'(1) << pos_q;
    leds_d = '0;
    case (mode_q)
      C_MODE_COUNT:   leds_d = step_q;
      C_MODE_CHASER:  leds_d = onehot;
      C_MODE_BLINK:   leds_d = {N_LEDS{blink_q}};
      C_MODE_BREATHE: leds_d = {N_LEDS{pwm_ctr_q < duty_q}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      step_q    <= '0;
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      duty_q    <= '0;
      ddir_q    <= DIR_UP;
      blink_q   <= 1'b0;
      pwm_ctr_q <= '0;
      mode_q    <= C_MODE_COUNT;
      leds_q    <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      step_q    <= step_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      ddir_q    <= ddir_d;
      blink_q   <= blink_d;
      pwm_ctr_q <= pwm_ctr_d;
      mode_q    <= mode_d;
      leds_q    <= leds_d;
      tick_q    <= tick_d;
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_led_pattern_gen : directed vector bench for led_pattern_gen            |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [2:0] leds;
  logic       tick;
  logic [0:0] leds1;
  logic       tick1;
  logic [2:0] leds_s;
  logic       tick_s;

  always #5 clk = ~clk;

  led_pattern_gen #(.N_LEDS(3), .PRESCALE_W(2), .PWM_W(3)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .leds(leds), .tick(tick));

  led_pattern_gen #(.N_LEDS(1), .PRESCALE_W(2), .PWM_W(3)) u_n1 (
    .clk(clk), .rst(rst), .mode(mode), .leds(leds1), .tick(tick1));

  // Tick period equals the PWM period here, so duty is constant per PWM window.
  led_pattern_gen #(.N_LEDS(3), .PRESCALE_W(3), .PWM_W(3)) u_slow (
    .clk(clk), .rst(rst), .mode(mode), .leds(leds_s), .tick(tick_s));

  typedef struct packed {
    logic       rst;
    logic [1:0] mode;
    logic [2:0] leds;
    logic       tick;
    logic       chk1;
    logic       leds1;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] chase_pat [6] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b001, 3'b010};
  int         duty_exp [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  int         total = 0;
  int         bad   = 0;
  int         on_cnt;
  int         waits;
  int         tick_cnt;
  logic       prev_tick;
  logic [2:0] prev_leds;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    mode = 2'd0;

    // Reset then count mode: edge k after release has tick=(k%4==0), leds=((k-1)/4)%8.
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    for (int k = 1; k <= 36; k++)
      vecs.push_back('{1'b0, 2'd0, 3'(((k - 1) / 4) % 8), (k % 4 == 0), 1'b0, 1'b0});
    // Switch to chaser at edge 37: leds still show the old count value (1).
    vecs.push_back('{1'b0, 2'd1, 3'b001, 1'b0, 1'b0, 1'b0});
    for (int k = 38; k <= 60; k++)
      vecs.push_back('{1'b0, 2'd1, chase_pat[(k - 37) / 4], (k % 4 == 0), 1'b1, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      rst  = vecs[i].rst;
      mode = vecs[i].mode;
      cyc();
      check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].leds));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tick));
      check($sformatf("vec%0d_tick_n1", i), 32'(tick1), 32'(vecs[i].tick));
      if (vecs[i].chk1) check($sformatf("vec%0d_leds_n1", i), 32'(leds1), 32'(vecs[i].leds1));
    end

    // Breathe: align to the slow tick, then on-count per 8-cycle window equals duty.
    mode  = 2'd3;
    waits = 0;
    while (tick_s !== 1'b1 && waits < 20) begin
      cyc();
      waits++;
    end
    check("breathe_tick_wait", 32'(tick_s), 32'd1);
    for (int j = 0; j < 15; j++) begin
      on_cnt = 0;
      for (int c = 0; c < 8; c++) begin
        cyc();
        on_cnt += int'(leds_s[0]);
      end
      check($sformatf("breathe_win%0d_on", j), 32'(on_cnt), 32'(duty_exp[j]));
      check($sformatf("breathe_win%0d_tick", j), 32'(tick_s), 32'd1);
    end

    // Count to step=5, then change to blink on the edge where the tick fires.
    rst  = 1'b1;
    mode = 2'd0;
    cyc();
    check("sw_rst_leds", 32'(leds), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      cyc();
      if (k == 20) check("sw_tick20", 32'(tick), 32'd1);
      if (k == 21) check("sw_step5", 32'(leds), 32'd5);
    end
    mode = 2'd2;
    cyc();
    check("sw_tick24", 32'(tick), 32'd1);
    for (int k = 25; k <= 33; k++) begin
      cyc();
      if (k <= 28) check($sformatf("sw_blink_off_%0d", k), 32'(leds), 32'd0);
      if (k == 29 || k == 32) check($sformatf("sw_blink_on_%0d", k), 32'(leds), 32'd7);
      if (k == 33) check("sw_blink_off_33", 32'(leds), 32'd0);
    end

    // Reset mid-chaser at pos=2; pattern and prescaler phase restart.
    rst = 1'b1;
    cyc();
    rst  = 1'b0;
    mode = 2'd1;
    for (int k = 1; k <= 9; k++) cyc();
    check("mid_pos2", 32'(leds), 32'b100);
    rst = 1'b1;
    cyc();
    check("mid_rst_leds", 32'(leds), 32'd0);
    check("mid_rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check($sformatf("mid_tick_%0d", k), 32'(tick), (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) check("mid_leds_1", 32'(leds), 32'd0);
      if (k >= 2 && k <= 4) check($sformatf("mid_leds_%0d", k), 32'(leds), 32'b001);
      if (k == 5) check("mid_leds_5", 32'(leds), 32'b010);
    end

    // Each mode held 64 cycles: single-cycle ticks, 16 per window, leds move only after a tick.
    prev_tick = tick;
    prev_leds = leds;
    for (int m = 0; m < 4; m++) begin
      mode     = 2'(m);
      tick_cnt = 0;
      for (int c = 0; c < 64; c++) begin
        cyc();
        if (tick) tick_cnt++;
        check($sformatf("hold_m%0d_c%0d_dbl", m, c), 32'(tick & prev_tick), 32'd0);
        if (m != 3 && c >= 2 && leds != prev_leds)
          check($sformatf("hold_m%0d_c%0d_leds", m, c), 32'(prev_tick), 32'd1);
        prev_tick = tick;
        prev_leds = leds;
      end
      check($sformatf("hold_m%0d_ticks", m), 32'(tick_cnt), 32'd16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
